// File: rtl/player_status_manager.sv
// rtl/player_status_manager.sv - per-frame resolution of collision flags into lives, score, power-ups and game-over
module player_status_manager #(
  parameter int INIT_LIVES      = 3,
  parameter int SCORE_PER_ALIEN = 10,
  parameter int MAX_SCORE       = 9999,
  parameter int GOD_FRAMES      = 150,
  parameter int TURBO_FRAMES    = 150,
  parameter int INVULN_FRAMES   = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [1:0]  alienHit,
  input  logic        playerHitByAlienPulse,
  input  logic [2:0]  playerHitByRocket,
  input  logic        PlayerHitBy_h_Rocket,
  input  logic        TurboCollision,
  input  logic        GodModeCollision,
  input  logic        aliensReachedBorder,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic        godModeActive,
  output logic        turboActive,
  output logic        playerVisible,
  output logic        lifeLostPulse,
  output logic        alienKilledPulse,
  output logic        gameOver
);

  localparam logic [1:0] PLAY      = 2'd0;
  localparam logic [1:0] HIT       = 2'd1;
  localparam logic [1:0] GAME_OVER = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  god_cnt_q, god_cnt_d;
  logic [7:0]  turbo_cnt_q, turbo_cnt_d;
  logic [7:0]  inv_cnt_q, inv_cnt_d;
  logic        visible_q, visible_d;
  logic        life_lost_q, life_lost_d;
  logic        alien_killed_q, alien_killed_d;
  logic [1:0]  hit_a_q, hit_a_d;
  logic        dmg_q, dmg_d;
  logic        turbo_q, turbo_d;
  logic        god_q, god_d;
  logic        border_q, border_d;

  logic        dmg_in;
  logic [1:0]  hit_cnt;
  logic [16:0] score_sum;

  always_comb begin
    dmg_in         = (|playerHitByRocket) | PlayerHitBy_h_Rocket | playerHitByAlienPulse;
    hit_cnt        = {1'b0, hit_a_q[0]} + {1'b0, hit_a_q[1]};
    score_sum      = {1'b0, score_q} + 17'(SCORE_PER_ALIEN) * 17'(hit_cnt);
    state_d        = state_q;
    lives_d        = lives_q;
    score_d        = score_q;
    god_cnt_d      = god_cnt_q;
    turbo_cnt_d    = turbo_cnt_q;
    inv_cnt_d      = inv_cnt_q;
    life_lost_d    = 1'b0;
    alien_killed_d = 1'b0;

    // On a resolution strobe the flags restart from this cycle's collisions only.
    if (startOfFrame) begin
      hit_a_d  = alienHit;
      dmg_d    = dmg_in;
      turbo_d  = TurboCollision;
      god_d    = GodModeCollision;
      border_d = aliensReachedBorder;
    end else begin
      hit_a_d  = hit_a_q | alienHit;
      dmg_d    = dmg_q | dmg_in;
      turbo_d  = turbo_q | TurboCollision;
      god_d    = god_q | GodModeCollision;
      border_d = border_q | aliensReachedBorder;
    end

    if (startOfFrame && state_q != GAME_OVER) begin
      if (border_q) begin
        state_d = GAME_OVER;
      end else begin
        if (state_q == HIT) begin
          inv_cnt_d = inv_cnt_q - 8'd1;
          if (inv_cnt_d == 8'd0) state_d = PLAY;
        end
        if (dmg_q && state_q == PLAY && god_cnt_q == 8'd0) begin
          lives_d     = lives_q - 3'd1;
          life_lost_d = 1'b1;
          if (lives_d == 3'd0) begin
            state_d = GAME_OVER;
          end else begin
            state_d   = HIT;
            inv_cnt_d = 8'(INVULN_FRAMES);
          end
        end
        if (|hit_a_q) begin
          score_d        = (score_sum > 17'(MAX_SCORE)) ? 16'(MAX_SCORE) : score_sum[15:0];
          alien_killed_d = 1'b1;
        end
        if (god_q) god_cnt_d = 8'(GOD_FRAMES);
        else if (god_cnt_q != 8'd0) god_cnt_d = god_cnt_q - 8'd1;
        if (turbo_q) turbo_cnt_d = 8'(TURBO_FRAMES);
        else if (turbo_cnt_q != 8'd0) turbo_cnt_d = turbo_cnt_q - 8'd1;
      end
    end

    if (state_d == GAME_OVER) begin
      god_cnt_d   = 8'd0;
      turbo_cnt_d = 8'd0;
      inv_cnt_d   = 8'd0;
    end

    // Blink: 4 frames on / 4 frames off while invulnerable.
    case (state_d)
      PLAY:    visible_d = 1'b1;
      HIT:     visible_d = ~inv_cnt_d[2];
      default: visible_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= PLAY;
      lives_q        <= 3'(INIT_LIVES);
      score_q        <= 16'd0;
      god_cnt_q      <= 8'd0;
      turbo_cnt_q    <= 8'd0;
      inv_cnt_q      <= 8'd0;
      visible_q      <= 1'b1;
      life_lost_q    <= 1'b0;
      alien_killed_q <= 1'b0;
      hit_a_q        <= 2'd0;
      dmg_q          <= 1'b0;
      turbo_q        <= 1'b0;
      god_q          <= 1'b0;
      border_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      score_q        <= score_d;
      god_cnt_q      <= god_cnt_d;
      turbo_cnt_q    <= turbo_cnt_d;
      inv_cnt_q      <= inv_cnt_d;
      visible_q      <= visible_d;
      life_lost_q    <= life_lost_d;
      alien_killed_q <= alien_killed_d;
      hit_a_q        <= hit_a_d;
      dmg_q          <= dmg_d;
      turbo_q        <= turbo_d;
      god_q          <= god_d;
      border_q       <= border_d;
    end
  end

  assign lives            = lives_q;
  assign score            = score_q;
  assign godModeActive    = (god_cnt_q != 8'd0);
  assign turboActive      = (turbo_cnt_q != 8'd0);
  assign playerVisible    = visible_q;
  assign lifeLostPulse    = life_lost_q;
  assign alienKilledPulse = alien_killed_q;
  assign gameOver         = (state_q == GAME_OVER);

endmodule

// File: tb/tb_player_status_manager.sv
// tb/tb_player_status_manager.sv - scoreboard bench for player_status_manager
module tb_player_status_manager;

  typedef struct packed {
    logic [2:0]  lives;
    logic [15:0] score;
    logic        go;
    logic        god;
    logic        turbo;
    logic        vis;
    logic        llp;
    logic        akp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic [1:0]  alienHit = 2'b0;
  logic        playerHitByAlienPulse = 1'b0;
  logic [2:0]  playerHitByRocket = 3'b0;
  logic        PlayerHitBy_h_Rocket = 1'b0;
  logic        TurboCollision = 1'b0;
  logic        GodModeCollision = 1'b0;
  logic        aliensReachedBorder = 1'b0;
  logic [2:0]  lives;
  logic [15:0] score;
  logic        godModeActive, turboActive, playerVisible;
  logic        lifeLostPulse, alienKilledPulse, gameOver;

  int    total = 0;
  int    bad = 0;
  string tname = "reset";
  exp_t  sb[$];
  logic  sof_pend = 1'b0;

  player_status_manager dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .alienHit(alienHit),
    .playerHitByAlienPulse(playerHitByAlienPulse), .playerHitByRocket(playerHitByRocket),
    .PlayerHitBy_h_Rocket(PlayerHitBy_h_Rocket), .TurboCollision(TurboCollision),
    .GodModeCollision(GodModeCollision), .aliensReachedBorder(aliensReachedBorder),
    .lives(lives), .score(score), .godModeActive(godModeActive), .turboActive(turboActive),
    .playerVisible(playerVisible), .lifeLostPulse(lifeLostPulse),
    .alienKilledPulse(alienKilledPulse), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s/%s: got %0d expected %0d at %0t", tname, name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int l, input int s, input bit go, input bit god,
                              input bit tb, input bit vis, input bit llp, input bit akp);
    exp_t e;
    e.lives = 3'(l); e.score = 16'(s); e.go = go; e.god = god;
    e.turbo = tb; e.vis = vis; e.llp = llp; e.akp = akp;
    return e;
  endfunction

  // Visibility k resolutions after the resolution that took a life (60-frame invulnerability).
  function automatic bit vis_after(input int k);
    int inv;
    if (k >= 60) return 1'b1;
    inv = 60 - k;
    return !inv[2];
  endfunction

  always @(posedge clk) sof_pend <= startOfFrame & ~reset;

  always @(negedge clk) begin
    exp_t e;
    if (sof_pend) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL %s/sb_empty: got resolution expected none", tname);
      end else begin
        e = sb.pop_front();
        chk("lives", lives, e.lives);
        chk("score", score, e.score);
        chk("gameOver", gameOver, e.go);
        chk("godModeActive", godModeActive, e.god);
        chk("turboActive", turboActive, e.turbo);
        chk("playerVisible", playerVisible, e.vis);
        chk("lifeLostPulse", lifeLostPulse, e.llp);
        chk("alienKilledPulse", alienKilledPulse, e.akp);
      end
    end else if (!reset) begin
      chk("lifeLostPulse_idle", lifeLostPulse, 0);
      chk("alienKilledPulse_idle", alienKilledPulse, 0);
    end
  end

  task automatic clear_inputs();
    alienHit = 2'b0; playerHitByAlienPulse = 1'b0; playerHitByRocket = 3'b0;
    PlayerHitBy_h_Rocket = 1'b0; TurboCollision = 1'b0; GodModeCollision = 1'b0;
    aliensReachedBorder = 1'b0;
  endtask

  task automatic do_reset(input string name);
    tname = name;
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_lives", lives, 3);
    chk("rst_score", score, 0);
    chk("rst_visible", playerVisible, 1);
    chk("rst_gameOver", gameOver, 0);
    chk("rst_god", godModeActive, 0);
    chk("rst_turbo", turboActive, 0);
    @(posedge clk); #1;
  endtask

  task automatic pix(input logic [1:0] ah, input logic [2:0] ph, input logic hr, input logic pa,
                     input logic tc, input logic gc, input logic br, input int n);
    alienHit = ah; playerHitByRocket = ph; PlayerHitBy_h_Rocket = hr;
    playerHitByAlienPulse = pa; TurboCollision = tc; GodModeCollision = gc;
    aliensReachedBorder = br;
    repeat (n) @(posedge clk);
    #1 clear_inputs();
  endtask

  task automatic sof(input exp_t e, input bit same_hit, input bit idle);
    startOfFrame = 1'b1;
    if (same_hit) playerHitByRocket = 3'b001;
    sb.push_back(e);
    @(posedge clk);
    #1 startOfFrame = 1'b0;
    playerHitByRocket = 3'b000;
    if (idle) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    // T1: rocket hit, blink through invulnerability, hits ignored while invulnerable
    do_reset("T1");
    pix(2'b00, 3'b001, 0, 0, 0, 0, 0, 1);
    sof(mk(2, 0, 0, 0, 0, vis_after(0), 1, 0), 0, 1);
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) pix(2'b00, 3'b000, 1, 0, 0, 0, 0, 1);
      sof(mk(2, 0, 0, 0, 0, vis_after(k), 0, 0), 0, 1);
    end
    pix(2'b00, 3'b000, 0, 1, 0, 0, 0, 2);
    sof(mk(1, 0, 0, 0, 0, vis_after(0), 1, 0), 0, 1);

    // T2: alien scoring, back-to-back SOF, saturation
    do_reset("T2");
    pix(2'b11, 3'b000, 0, 0, 0, 0, 0, 40);
    sof(mk(3, 20, 0, 0, 0, 1, 0, 1), 0, 1);
    pix(2'b10, 3'b000, 0, 0, 0, 0, 0, 1);
    sof(mk(3, 30, 0, 0, 0, 1, 0, 1), 0, 0);
    sof(mk(3, 30, 0, 0, 0, 1, 0, 0), 0, 1);
    s = 30;
    for (int i = 0; i < 498; i++) begin
      pix(2'b11, 3'b000, 0, 0, 0, 0, 0, 1);
      s += 20;
      sof(mk(3, s, 0, 0, 0, 1, 0, 1), 0, 1);
    end
    pix(2'b11, 3'b000, 0, 0, 0, 0, 0, 3);
    sof(mk(3, 9999, 0, 0, 0, 1, 0, 1), 0, 1);
    pix(2'b01, 3'b000, 0, 0, 0, 0, 0, 1);
    sof(mk(3, 9999, 0, 0, 0, 1, 0, 1), 0, 1);
    sof(mk(3, 9999, 0, 0, 0, 1, 0, 0), 0, 1);

    // T3: god + turbo pickup with a hit in the same frame; god shields later hits
    do_reset("T3");
    pix(2'b00, 3'b100, 0, 0, 1, 1, 0, 1);
    sof(mk(2, 0, 0, 1, 1, vis_after(0), 1, 0), 0, 1);
    for (int k = 1; k <= 150; k++) begin
      if (k == 1 || k == 70) pix(2'b00, 3'b010, 0, 0, 0, 0, 0, 1);
      sof(mk(2, 0, 0, k < 150, k < 150, vis_after(k), 0, 0), 0, 1);
    end
    pix(2'b00, 3'b010, 0, 0, 0, 0, 0, 1);
    sof(mk(1, 0, 0, 0, 0, vis_after(0), 1, 0), 0, 1);

    // T4: three spaced hits end the game; game over is absorbing
    do_reset("T4");
    for (int h = 0; h < 2; h++) begin
      pix(2'b00, 3'b001, 0, 0, 0, 0, 0, 1);
      sof(mk(2 - h, 0, 0, 0, 0, vis_after(0), 1, 0), 0, 1);
      for (int k = 1; k <= 61; k++) sof(mk(2 - h, 0, 0, 0, 0, vis_after(k), 0, 0), 0, 1);
    end
    pix(2'b00, 3'b001, 0, 0, 0, 0, 0, 1);
    sof(mk(0, 0, 1, 0, 0, 0, 1, 0), 0, 1);
    pix(2'b11, 3'b111, 1, 1, 1, 1, 1, 2);
    sof(mk(0, 0, 1, 0, 0, 0, 0, 0), 1, 1);
    sof(mk(0, 0, 1, 0, 0, 0, 0, 0), 0, 1);

    // T5: border ends the game even under god mode, lives held
    do_reset("T5");
    pix(2'b00, 3'b000, 0, 0, 0, 1, 0, 1);
    sof(mk(3, 0, 0, 1, 0, 1, 0, 0), 0, 1);
    pix(2'b00, 3'b000, 0, 0, 0, 0, 1, 1);
    sof(mk(3, 0, 1, 0, 0, 0, 0, 0), 0, 1);

    // T6: hit coincident with SOF counts toward the next frame
    do_reset("T6");
    sof(mk(3, 0, 0, 0, 0, 1, 0, 0), 1, 1);
    sof(mk(2, 0, 0, 0, 0, vis_after(0), 1, 0), 0, 1);

    // T7: reset mid-frame discards latched collisions
    do_reset("T7");
    pix(2'b11, 3'b001, 0, 0, 0, 0, 0, 1);
    do_reset("T7");
    sof(mk(3, 0, 0, 0, 0, 1, 0, 0), 0, 1);

    tname = "drain";
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
